// File: rtl/sdc_init_seq.sv
// SD-card SPI-mode init sequencer: CMD0, CMD8, CMD55/ACMD41 loop, optional CMD16.
// Define SDC_INIT_CMD16_EN to add the CMD16 (512-byte block length) step before READY.
module sdc_init_seq #(
  parameter int unsigned POWERUP_WAIT   = 1000,
  parameter int unsigned RESP_TIMEOUT   = 65535,
  parameter int unsigned ACMD41_MAX_TRY = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [7:0]  o_cmd,
  output logic [31:0] o_arg,
  output logic [7:0]  o_crc,
  output logic        o_we,
  input  logic        i_done,
  input  logic [7:0]  i_res,
  output logic        o_busy,
  output logic        o_ready,
  output logic        o_error,
  output logic [3:0]  o_err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_PWR_WAIT, S_ISSUE, S_WAIT_RESP, S_CHECK, S_READY, S_ERROR
  } state_t;

  // Step encodings double as the error code of a failing step.
  typedef enum logic [2:0] {
    ST_NONE   = 3'd0,
    ST_CMD0   = 3'd1,
    ST_CMD8   = 3'd2,
    ST_CMD55  = 3'd3,
`ifdef SDC_INIT_CMD16_EN
    ST_ACMD41 = 3'd4,
    ST_CMD16  = 3'd5
`else
    ST_ACMD41 = 3'd4
`endif
  } step_t;

  localparam logic [15:0] TRY_MAX = 16'(ACMD41_MAX_TRY);

  state_t      state;
  step_t       step;
  step_t       nxt_step;
  logic [31:0] cnt;
  logic [15:0] tries;
  logic [15:0] tries_inc;
  logic [7:0]  resp;
  logic        chk_ok;
  logic        chk_done;
  logic [3:0]  chk_err;

  // {cmd, arg, crc} for each step
  function automatic logic [47:0] cmd_of(input step_t s);
    case (s)
      ST_CMD0:   return {8'h40, 32'h0000_0000, 8'h95};
      ST_CMD8:   return {8'h48, 32'h0000_01AA, 8'h87};
      ST_CMD55:  return {8'h77, 32'h0000_0000, 8'h65};
      ST_ACMD41: return {8'h69, 32'h4000_0000, 8'h77};
`ifdef SDC_INIT_CMD16_EN
      ST_CMD16:  return {8'h50, 32'h0000_0200, 8'h01};
`endif
      default:   return 48'h0;
    endcase
  endfunction

  always_comb begin
    tries_inc = (tries == 16'hFFFF) ? tries : tries + 16'd1;
    nxt_step  = step;
    chk_ok    = 1'b0;
    chk_done  = 1'b0;
    chk_err   = {1'b0, step};
    case (step)
      ST_CMD0:  if (resp == 8'h01) begin chk_ok = 1'b1; nxt_step = ST_CMD8; end
      ST_CMD8:  if (resp == 8'h01) begin chk_ok = 1'b1; nxt_step = ST_CMD55; end
      ST_CMD55: if (resp == 8'h01 || resp == 8'h00) begin chk_ok = 1'b1; nxt_step = ST_ACMD41; end
      ST_ACMD41: begin
        if (resp == 8'h00) begin
          chk_ok = 1'b1;
`ifdef SDC_INIT_CMD16_EN
          nxt_step = ST_CMD16;
`else
          chk_done = 1'b1;
`endif
        end else if (resp == 8'h01) begin
          if (tries_inc == TRY_MAX) chk_err = 4'd6;
          else begin chk_ok = 1'b1; nxt_step = ST_CMD55; end
        end
      end
`ifdef SDC_INIT_CMD16_EN
      ST_CMD16: if (resp == 8'h00) begin chk_ok = 1'b1; chk_done = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      step       <= ST_NONE;
      cnt        <= '0;
      tries      <= '0;
      resp       <= '0;
      o_cmd      <= '0;
      o_arg      <= '0;
      o_crc      <= '0;
      o_we       <= 1'b0;
      o_busy     <= 1'b0;
      o_ready    <= 1'b0;
      o_error    <= 1'b0;
      o_err_code <= '0;
    end else begin
      o_we <= 1'b0;
      case (state)
        S_IDLE, S_READY, S_ERROR: begin
          if (i_start) begin
            o_ready    <= 1'b0;
            o_error    <= 1'b0;
            o_err_code <= '0;
            o_busy     <= 1'b1;
            cnt        <= '0;
            tries      <= '0;
            state      <= S_PWR_WAIT;
          end
        end
        S_PWR_WAIT: begin
          if (cnt + 32'd1 >= POWERUP_WAIT) begin
            step                   <= ST_CMD0;
            {o_cmd, o_arg, o_crc}  <= cmd_of(ST_CMD0);
            o_we                   <= 1'b1;
            state                  <= S_ISSUE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        // o_we is already high for this cycle; cnt counts cycles since it rose.
        S_ISSUE: begin
          cnt   <= 32'd1;
          state <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (i_done) begin
            resp  <= i_res;
            state <= S_CHECK;
          end else if (cnt + 32'd1 >= RESP_TIMEOUT) begin
            o_error    <= 1'b1;
            o_busy     <= 1'b0;
            o_err_code <= {1'b1, step};
            state      <= S_ERROR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_CHECK: begin
          if (step == ST_ACMD41 && resp == 8'h01) tries <= tries_inc;
          if (!chk_ok) begin
            o_error    <= 1'b1;
            o_busy     <= 1'b0;
            o_err_code <= chk_err;
            state      <= S_ERROR;
          end else if (chk_done) begin
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            state   <= S_READY;
          end else begin
            step                  <= nxt_step;
            {o_cmd, o_arg, o_crc} <= cmd_of(nxt_step);
            o_we                  <= 1'b1;
            state                 <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_init_seq.sv
// Bench for sdc_init_seq: responder model replies to each o_we from a queue;
// expected command bytes are queued per scenario and popped against observed issues.
module tb_sdc_init_seq;
  localparam int PW = 10;
  localparam int RT = 100;
  localparam int MT = 3;

  logic        clk = 1'b0;
  logic        rst, start, done;
  logic [7:0]  res;
  logic [7:0]  cmd, crc;
  logic [31:0] arg;
  logic        we, busy, ready, error;
  logic [3:0]  err_code;

  int checks = 0;
  int failures = 0;

  logic [7:0]  rsp_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_cmd[$];
  logic [31:0] obs_arg[$];
  logic [7:0]  obs_crc[$];
  int          we_cyc[$];
  int          end_cyc;
  logic        busy0, err0, rdy0;

  always #5 clk = ~clk;

  sdc_init_seq #(.POWERUP_WAIT(PW), .RESP_TIMEOUT(RT), .ACMD41_MAX_TRY(MT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_cmd(cmd), .o_arg(arg), .o_crc(crc), .o_we(we),
    .i_done(done), .i_res(res),
    .o_busy(busy), .o_ready(ready), .o_error(error), .o_err_code(err_code)
  );

  function automatic logic [31:0] tbl_arg(input logic [7:0] c);
    case (c)
      8'h48:   return 32'h0000_01AA;
      8'h69:   return 32'h4000_0000;
      8'h50:   return 32'h0000_0200;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] tbl_crc(input logic [7:0] c);
    case (c)
      8'h40:   return 8'h95;
      8'h48:   return 8'h87;
      8'h77:   return 8'h65;
      8'h69:   return 8'h77;
      8'h50:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Pulse start, then act as the command engine: every o_we gets the next
  // queued reply 3 cycles later (no reply once the queue is empty).
  task automatic run_session(input bit stop_en, input logic [7:0] stop_cmd, input int budget);
    int  wait_n = 0;
    bit  pending = 0;
    obs_cmd.delete(); obs_arg.delete(); obs_crc.delete(); we_cyc.delete();
    end_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    busy0 = busy; err0 = error; rdy0 = ready;
    for (int c = 0; c < budget; c++) begin
      if (we) begin
        obs_cmd.push_back(cmd); obs_arg.push_back(arg); obs_crc.push_back(crc);
        we_cyc.push_back(c);
        if (rsp_q.size() > 0) begin pending = 1; wait_n = 3; end
        if (stop_en && cmd == stop_cmd) begin end_cyc = c; break; end
      end
      if (ready || error) begin end_cyc = c; break; end
      done = 1'b0;
      if (pending) begin
        if (wait_n == 0) begin done = 1'b1; res = rsp_q.pop_front(); pending = 0; end
        else wait_n--;
      end
      @(negedge clk);
    end
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; done = 1'b0; res = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({we, busy, ready, error, err_code, cmd, arg, crc} !== 56'h0)
      begin failures++; $display("FAIL reset_outputs: got %h want 0", {we, busy, ready, error, err_code, cmd, arg, crc}); end
    rst = 1'b0;
  endtask

  task automatic test_happy();
    int n41 = 0;
    logic [7:0] e, g;
    rsp_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    exp_q = '{8'h40, 8'h48, 8'h77, 8'h69, 8'h77, 8'h69};
`ifdef SDC_INIT_CMD16_EN
    rsp_q.push_back(8'h00); exp_q.push_back(8'h50);
`endif
    run_session(1'b0, 8'h00, 600);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL happy_busy: got %b want 1", busy0); end
    foreach (obs_cmd[i]) if (obs_cmd[i] == 8'h69) n41++;
    checks++; if (n41 != 2) begin failures++; $display("FAIL happy_acmd41_count: got %0d want 2", n41); end
    checks++; if (obs_cmd.size() != exp_q.size())
      begin failures++; $display("FAIL happy_issue_count: got %0d want %0d", obs_cmd.size(), exp_q.size()); end
    checks++; if (we_cyc.size() < 2 || we_cyc[0] != PW || we_cyc[1] - we_cyc[0] != 5)
      begin failures++; $display("FAIL happy_latency: got first=%0d n=%0d want first=%0d gap=5", (we_cyc.size() > 0) ? we_cyc[0] : -1, we_cyc.size(), PW); end
    while (exp_q.size() > 0 && obs_cmd.size() > 0) begin
      e = exp_q.pop_front(); g = obs_cmd.pop_front();
      checks++;
      if (g !== e || obs_arg[0] !== tbl_arg(e) || obs_crc[0] !== tbl_crc(e))
        begin failures++; $display("FAIL happy_cmd: got %h/%h/%h want %h/%h/%h", g, obs_arg[0], obs_crc[0], e, tbl_arg(e), tbl_crc(e)); end
      void'(obs_arg.pop_front()); void'(obs_crc.pop_front());
    end
    checks++; if ({ready, error, busy} !== 3'b100)
      begin failures++; $display("FAIL happy_ready: got rdy/err/busy=%b want 100", {ready, error, busy}); end
  endtask

  task automatic test_cmd8_err();
    int extra = 0;
    rsp_q = '{8'h01, 8'h05};
    exp_q = '{8'h40, 8'h48};
    run_session(1'b0, 8'h00, 600);
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL cmd8_ready_cleared: got %b want 0", rdy0); end
    checks++; if (obs_cmd != exp_q)
      begin failures++; $display("FAIL cmd8_seq: got %p want %p", obs_cmd, exp_q); end
    exp_q.delete();
    checks++; if ({error, busy, err_code} !== {1'b1, 1'b0, 4'd2})
      begin failures++; $display("FAIL cmd8_err: got err/busy/code=%b/%b/%0d want 1/0/2", error, busy, err_code); end
    repeat (20) begin @(negedge clk); if (we) extra++; end
    checks++; if (extra != 0) begin failures++; $display("FAIL cmd8_no_more_we: got %0d want 0", extra); end
  endtask

  task automatic test_timeout();
    rsp_q.delete();
    run_session(1'b0, 8'h00, 400);
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL timeout_err_cleared: got %b want 0", err0); end
    checks++; if (obs_cmd.size() != 1 || obs_cmd[0] !== 8'h40)
      begin failures++; $display("FAIL timeout_issue: got n=%0d want one CMD0", obs_cmd.size()); end
    checks++; if ({error, err_code} !== {1'b1, 4'd9})
      begin failures++; $display("FAIL timeout_code: got err=%b code=%0d want 1/9", error, err_code); end
    checks++; if (we_cyc.size() == 0 || end_cyc - we_cyc[0] != RT)
      begin failures++; $display("FAIL timeout_cycles: got %0d want %0d", (we_cyc.size() > 0) ? end_cyc - we_cyc[0] : -1, RT); end
  endtask

  task automatic test_retry();
    int n41 = 0;
    rsp_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_session(1'b0, 8'h00, 800);
    checks++; if ({busy0, err0} !== 2'b10)
      begin failures++; $display("FAIL retry_start: got busy/err=%b want 10", {busy0, err0}); end
    foreach (obs_cmd[i]) if (obs_cmd[i] == 8'h69) n41++;
    checks++; if (n41 != MT) begin failures++; $display("FAIL retry_acmd41_count: got %0d want %0d", n41, MT); end
    checks++; if ({error, busy, err_code} !== {1'b1, 1'b0, 4'd6})
      begin failures++; $display("FAIL retry_code: got err/busy/code=%b/%b/%0d want 1/0/6", error, busy, err_code); end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    rsp_q = '{8'h01, 8'h01, 8'h01};
    run_session(1'b1, 8'h69, 600);
    checks++; if (obs_cmd.size() != 4 || obs_cmd[3] !== 8'h69)
      begin failures++; $display("FAIL rstmid_reach_acmd41: got n=%0d want 4", obs_cmd.size()); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({we, busy, ready, error, err_code, cmd, arg, crc} !== 56'h0)
      begin failures++; $display("FAIL rstmid_outputs: got %h want 0", {we, busy, ready, error, err_code, cmd, arg, crc}); end
    rst = 1'b0;
    repeat (RT + 20) begin @(negedge clk); if (we || error) extra++; end
    checks++; if (extra != 0) begin failures++; $display("FAIL rstmid_quiet: got %0d want 0", extra); end
    rsp_q = '{8'h01, 8'h01, 8'h01, 8'h00};
`ifdef SDC_INIT_CMD16_EN
    rsp_q.push_back(8'h00);
`endif
    run_session(1'b0, 8'h00, 600);
    checks++; if (we_cyc.size() == 0 || we_cyc[0] != PW || obs_cmd[0] !== 8'h40)
      begin failures++; $display("FAIL rstmid_restart: got first_we=%0d want %0d with CMD0", (we_cyc.size() > 0) ? we_cyc[0] : -1, PW); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b want 1", ready); end
  endtask

`ifdef SDC_INIT_CMD16_EN
  task automatic test_cmd16();
    rsp_q = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    run_session(1'b0, 8'h00, 600);
    checks++; if (obs_cmd.size() != 5 || obs_cmd[4] !== 8'h50 || obs_arg[4] !== 32'h0000_0200)
      begin failures++; $display("FAIL cmd16_issue: got n=%0d want CMD16 arg 200 last", obs_cmd.size()); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL cmd16_ready: got %b want 1", ready); end
    rsp_q = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h04};
    run_session(1'b0, 8'h00, 600);
    checks++; if ({error, err_code} !== {1'b1, 4'd5})
      begin failures++; $display("FAIL cmd16_err: got err=%b code=%0d want 1/5", error, err_code); end
  endtask
`endif

  initial begin
    test_reset();
    test_happy();
    test_cmd8_err();
    test_timeout();
    test_retry();
    test_reset_mid();
`ifdef SDC_INIT_CMD16_EN
    test_cmd16();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdc_init_seq.md
Name: sdc_init_seq

Overview:
Sequencer that drives the SPI SD-card command engine through the SD SPI-mode initialisation flow: CMD0, CMD8, then a CMD55/ACMD41 loop, with CMD16 optional. It sits between top-level control and the command engine. It issues one command at a time via the engine's write strobe and checks each returned R1 byte. It reports ready or a coded error.

Parameters:
POWERUP_WAIT, 1000, clock cycles to wait after i_start before CMD0 (card power-up/dummy-clock window)
RESP_TIMEOUT, 65535, max cycles to wait for i_done per command before error
ACMD41_MAX_TRY, 1000, max CMD55/ACMD41 iterations before error

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse; begins init when idle or after error
o_cmd  out  8  command byte to engine (0x40|index)
o_arg  out  32  command argument to engine
o_crc  out  8  CRC byte to engine
o_we  out  1  one-cycle issue strobe to engine
i_done  in  1  one-cycle pulse from engine; i_res valid this cycle
i_res  in  8  R1 response byte from engine
o_busy  out  1  high from accepted i_start until READY or ERROR
o_ready  out  1  card initialised; held until i_rst or next i_start
o_error  out  1  init failed; held until i_rst or next i_start
o_err_code  out  4  failing step: 1=CMD0, 2=CMD8, 3=CMD55, 4=ACMD41, 5=CMD16, 6=ACMD41 retries exhausted; bit-OR 8 when the failure was a timeout

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE. o_we=0, o_busy=0, o_ready=0, o_error=0, o_err_code=0, o_cmd=0, o_arg=0, o_crc=0, all counters 0. Reset mid-command aborts immediately; no further o_we is issued.
- States: IDLE, PWR_WAIT, ISSUE, WAIT_RESP, CHECK, READY, ERROR. A step register (CMD0, CMD8, CMD55, ACMD41, CMD16) selects the command.
- IDLE/READY/ERROR + i_start: clear o_ready/o_error/o_err_code, set o_busy, go to PWR_WAIT. i_start is ignored while o_busy=1.
- PWR_WAIT: count POWERUP_WAIT cycles, then step=CMD0, go to ISSUE.
- ISSUE: drive o_cmd/o_arg/o_crc for the step and assert o_we for exactly one cycle, then go to WAIT_RESP. o_cmd/o_arg/o_crc stay stable until the next ISSUE.
- Command table:
  - CMD0: 0x40, 0x00000000, 0x95
  - CMD8: 0x48, 0x000001AA, 0x87
  - CMD55: 0x77, 0x00000000, 0x65
  - ACMD41: 0x69, 0x40000000, 0x77
  - CMD16: 0x50, 0x00000200, 0x01
- WAIT_RESP: count cycles. On i_done, latch i_res and go to CHECK. If the count reaches RESP_TIMEOUT without i_done, go to ERROR with the timeout bit set. i_done arriving in the same cycle as the timeout limit is treated as done. i_done in any other state is ignored.
- CHECK (1 cycle):
  - CMD0: 0x01 -> CMD8; else error 1.
  - CMD8: 0x01 -> CMD55; else error 2. v1 cards are unsupported.
  - CMD55: 0x01 or 0x00 -> ACMD41; else error 3.
  - ACMD41: 0x00 -> CMD16 (feature on) or READY. 0x01 -> increment the try counter; if the counter equals ACMD41_MAX_TRY -> error 6, else back to CMD55. Other values -> error 4.
  - CMD16: 0x00 -> READY; else error 5.
- Latency: ISSUE to o_we is 0 cycles (o_we is registered in ISSUE). CHECK to the next o_we is 1 cycle.
- READY: o_ready=1, o_busy=0. ERROR: o_error=1, o_busy=0, o_err_code held.
- Try counter is 16-bit and saturating. It clears only on i_start or i_rst.

Optional Feature:
SDC_INIT_CMD16_EN
- Defined: after ACMD41 returns 0x00, issue CMD16 (block length 512) and require 0x00 before READY.
- Undefined: the CMD16 step and error code 5 do not exist; ACMD41 0x00 goes straight to READY.

Test Plan:
1. Happy path with a responder model replying 0x01, 0x01, 0x01, 0x01, 0x01, 0x00 (CMD0, CMD8, CMD55, ACMD41, CMD55, ACMD41) -> o_we sequence 0x40, 0x48, 0x77, 0x69, 0x77, 0x69; o_ready=1; o_error=0; exactly 2 ACMD41 issues.
2. CMD8 replies 0x05 -> o_error=1, o_err_code=2, no further o_we, o_busy=0.
3. Engine never asserts i_done after CMD0, with RESP_TIMEOUT=100 -> o_error=1, o_err_code=9 exactly 100 cycles after the o_we cycle.
4. ACMD41 always replies 0x01, with ACMD41_MAX_TRY=3 -> 3 ACMD41 issues, then o_err_code=6.
5. Assert i_rst during WAIT_RESP of ACMD41, then pulse i_start -> all outputs 0 on reset; full sequence restarts from PWR_WAIT and CMD0.
6. With SDC_INIT_CMD16_EN defined, after ACMD41 0x00 -> o_cmd=0x50, o_arg=0x00000200. CMD16 reply 0x00 -> o_ready=1; reply 0x04 -> o_err_code=5.
